keypad_scan_decoder: RTL and testbench
======================================

Name: keypad_scan_decoder

Overview:
- Input Unit (IU) block. It is the input-side counterpart of the Output Unit's multiplexed 7-segment display controller.
- The display controller drives one-hot digit strobes out and shows a hex nibble.
- This block drives one-hot column strobes out to a 4x4 matrix keypad, samples the row lines, debounces, and decodes the pressed key to a 4-bit calculator key code.
- Each debounced press produces exactly one key_valid pulse, consumed by the calculator control unit.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (column dwell). Must be >= 4.
- DEBOUNCE_CNT, 4: consecutive identical samples (one per dwell) required to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ROW  input  [3:0]  keypad rows, active-low (external pull-ups), asynchronous to clk
- COL  output [3:0]  keypad column drive, active-low one-hot
- KEY  output [3:0]  decoded key code of the last accepted press
- key_valid  output  1  one-cycle pulse when KEY is updated
- key_held  output  1  high while the accepted key is still pressed (until release is debounced)

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values: COL=4'b1110 (column 0), KEY=4'h0, key_valid=0, key_held=0, state SCAN, all counters 0.
- Synchronizer: ROW passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Dwell counter:
  - counts 0..SCAN_DIV-1 and wraps.
  - The sample point is the cycle with count == SCAN_DIV-1.
  - The column changes only on wrap. This gives >= SCAN_DIV-1 cycles of settling before sampling.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits = their value; A=+ (4'hA), B=- (4'hB), C=x (4'hC), D=/ (4'hD), * = clear (4'hE), # = equals (4'hF).
- Multiple rows low at a sample: lowest row index wins. Keys in other columns are ignored while the column is frozen.
- SCAN state:
  - At each sample, if rs==4'hF, rotate COL to the next column (3 wraps to 0).
  - Otherwise latch (row, col) and set deb_cnt=1. If DEBOUNCE_CNT==1, accept immediately; otherwise go to DEBOUNCE. COL is frozen.
- DEBOUNCE state, at each sample:
  - Same row still low: increment deb_cnt. When deb_cnt reaches DEBOUNCE_CNT, accept.
  - Row released or a different row wins: return to SCAN, advance COL to the next column, deb_cnt=0, no pulse.
- Accept action:
  - In the clock following the deciding sample: KEY <= code, key_valid=1 for exactly one cycle, key_held=1.
  - Go to HELD.
  - Latency: key_valid rises 1 clk after the DEBOUNCE_CNT-th consecutive pressed sample.
- HELD state:
  - COL stays frozen; no repeat pulses.
  - At each sample, a released row increments rel_cnt; a pressed row clears rel_cnt.
  - When rel_cnt reaches DEBOUNCE_CNT: key_held=0, rel_cnt=0, return to SCAN, advance COL.
- KEY holds its value until the next accepted press. It is never cleared except by rst.
- Reset mid-operation: all outputs return to reset values in the same cycle rst asserts; no key_valid is produced. After rst deasserts, scanning restarts at column 0.
- The state machine is synchronous to clk; only the reset is asynchronous.

Decomposition:
- Shared package calc_keys_pkg:
  - key code localparams: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_DIV=4'hD, KEY_CLR=4'hE, KEY_EQ=4'hF
  - state enum {SCAN, DEBOUNCE, HELD}
  - keymap function (row, col) -> code
- One natural sub-module: scan_timer, holding the dwell counter and the sample-strobe generator.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset: assert rst, ROW=4'hF -> COL=4'b1110, KEY=0, key_valid=0, key_held=0. With no keys pressed after release, COL rotates 1110->1101->1011->0111->1110, one step every 4 clk.
- Press '5' (ROW[1] low when COL[1] low, held 40 clk) -> exactly one key_valid pulse, KEY=4'h5, key_held=1. Release -> key_held falls after 3 released samples (~12 clk).
- Bounce: '9' pressed for 2 samples then released -> no key_valid, KEY unchanged, scanning resumes at column 3.
- Long hold of '#' for 200 clk -> single key_valid, KEY=4'hF. Release, then press 'A' -> second pulse with KEY=4'hA.
- Two keys in column 3 (rows 0 and 2 low) -> KEY=4'hA (lowest row wins), one pulse.
- rst asserted while in DEBOUNCE (after 2 pressed samples) -> outputs immediately at reset values, no pulse. Key held through rst release -> press re-debounced from column 0 and accepted once.

Source files
------------

// File: rtl/calc_keys_pkg.sv
// Shared calculator key definitions: key codes, scanner states and the 4x4 keypad map.
package calc_keys_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    // Row r, column c of the physical keypad to the calculator key code.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        unique case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_CLR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_EQ;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column dwell counter; flags the last cycle of each dwell as the row sample point.
module scan_timer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic sample
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sample = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: drives one-hot columns, debounces rows, emits one pulse per press.
module keypad_scan_decoder
    import calc_keys_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);

    logic          sample;
    logic [3:0]    row_meta_q, rs_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [DW-1:0] rel_q, rel_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic          hit;
    logic [1:0]    win_row;
    logic [DW-1:0] deb_inc, rel_inc;

    scan_timer #(
        .SCAN_DIV(SCAN_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .sample(sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            rs_q       <= 4'hF;
        end else begin
            row_meta_q <= ROW;
            rs_q       <= row_meta_q;
        end
    end

    always_comb begin
        hit     = (rs_q != 4'hF);
        win_row = low_row(rs_q);
        deb_inc = deb_q + 1'b1;
        rel_inc = rel_q + 1'b1;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        deb_d   = deb_q;
        rel_d   = rel_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (!hit) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d = win_row;
                        deb_d = DEB_ONE;
                        if (DEB_MAX == DEB_ONE) begin
                            key_d   = keymap(win_row, col_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                            rel_d   = '0;
                            state_d = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hit && (win_row == row_q)) begin
                        deb_d = deb_inc;
                        if (deb_inc == DEB_MAX) begin
                            key_d   = keymap(row_q, col_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                            rel_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 1'b1;
                        deb_d   = '0;
                    end
                end
                HELD: begin
                    // Only the latched row matters; other keys in the column are ignored.
                    if (rs_q[row_q]) begin
                        if (rel_inc == DEB_MAX) begin
                            held_d  = 1'b0;
                            rel_d   = '0;
                            state_d = SCAN;
                            col_d   = col_q + 1'b1;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            deb_q   <= '0;
            rel_q   <= '0;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        COL = ~(4'b0001 << col_q);
    end

    assign KEY       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with a sample-level behavioural keypad model.
module tb_keypad_scan_decoder;

    localparam int SD = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [3:0] KEY;
    logic       key_valid;
    logic       key_held;

    bit pressed [16];
    int vectors     = 0;
    int miscompares = 0;
    int dut_pulses  = 0;
    int base;

    // Key code by r*4+c: 1 2 3 + / 4 5 6 - / 7 8 9 x / clr 0 = div
    int codes [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    always #5 clk = ~clk;

    keypad_scan_decoder #(
        .SCAN_DIV    (SD),
        .DEBOUNCE_CNT(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ROW      (ROW),
        .COL      (COL),
        .KEY      (KEY),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key shorts its row to a driven-low column.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !COL[c]) ROW[r] = 1'b0;
    end

    function automatic logic [3:0] kp(input int colidx);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            if (pressed[r*4+colidx]) rows[r] = 1'b0;
        return rows;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which column is scanned, whether a candidate key is latched, and streak lengths.
    int         m_cyc, m_col, m_row, m_streak, m_rel, m_low;
    bit         m_frozen, m_holding, m_valid, m_held;
    logic [3:0] m_s1, m_s2, m_key, m_now;

    task automatic m_accept();
        m_key     = 4'(codes[m_row*4+m_col]);
        m_valid   = 1'b1;
        m_held    = 1'b1;
        m_holding = 1'b1;
        m_streak  = 0;
        m_rel     = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_col = 0; m_row = 0; m_streak = 0; m_rel = 0;
            m_frozen = 0; m_holding = 0; m_valid = 0; m_held = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_key = 4'h0;
        end else begin
            m_now   = kp(m_col);
            m_valid = 1'b0;
            if (m_cyc % SD == SD - 1) begin
                m_low = -1;
                for (int r = 3; r >= 0; r--) if (!m_s2[r]) m_low = r;
                if (!m_frozen) begin
                    if (m_low < 0) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        m_frozen = 1; m_row = m_low; m_streak = 1;
                        if (m_streak == DC) m_accept();
                    end
                end else if (!m_holding) begin
                    if (m_low == m_row) begin
                        m_streak++;
                        if (m_streak == DC) m_accept();
                    end else begin
                        m_frozen = 0; m_streak = 0; m_col = (m_col + 1) % 4;
                    end
                end else begin
                    if (m_s2[m_row]) begin
                        m_rel++;
                        if (m_rel == DC) begin
                            m_held = 0; m_holding = 0; m_frozen = 0; m_rel = 0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = m_now;
            m_cyc++;
        end
    end

    logic [3:0] exp_col;
    always @(posedge clk) begin
        #1;
        if (key_valid) dut_pulses++;
        exp_col = 4'hF;
        exp_col[m_col] = 1'b0;
        check("cycle {COL,KEY,valid,held}", {COL, KEY, key_valid, key_held},
              {exp_col, m_key, m_valid, m_held});
    end

    task automatic release_all();
        for (int i = 0; i < 16; i++) pressed[i] = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int b0;
        bit got;
        b0  = dut_pulses;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #2;
            if (dut_pulses > b0) got = 1'b1;
        end
        check({name, " pulse seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_held_low(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #2;
            if (!key_held) got = 1'b1;
        end
        check({name, " held fell"}, 32'(got), 32'd1);
    endtask

    // Returns just after the edge on which COL switches to target (start of its dwell).
    task automatic wait_col_enter(input string name, input logic [3:0] target);
        logic [3:0] prev;
        bit got;
        prev = COL;
        got  = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (COL == target && prev != target) got = 1'b1;
            prev = COL;
        end
        check({name, " column reached"}, 32'(got), 32'd1);
    endtask

    initial begin
        release_all();
        repeat (3) @(negedge clk);
        check("reset COL", 32'(COL), 32'h0000000E);
        check("reset KEY", 32'(KEY), 32'h0);
        check("reset valid", 32'(key_valid), 32'h0);
        check("reset held", 32'(key_held), 32'h0);
        rst = 1'b0;

        // Idle rotation, one step per dwell.
        repeat (4) @(posedge clk); #1 check("rotate col1", 32'(COL), 32'hD);
        repeat (4) @(posedge clk); #1 check("rotate col2", 32'(COL), 32'hB);
        repeat (4) @(posedge clk); #1 check("rotate col3", 32'(COL), 32'h7);
        repeat (4) @(posedge clk); #1 check("rotate wrap", 32'(COL), 32'hE);

        // '5' press and release.
        @(negedge clk);
        base = dut_pulses;
        pressed[1*4+1] = 1'b1;
        wait_pulse("key5", 100);
        repeat (30) @(posedge clk); #2;
        check("key5 pulses", 32'(dut_pulses - base), 32'd1);
        check("key5 KEY", 32'(KEY), 32'h5);
        check("key5 held", 32'(key_held), 32'd1);
        @(negedge clk);
        release_all();
        wait_held_low("key5", 16);

        // '9' bounce: exactly two pressed samples.
        wait_col_enter("bounce9", 4'hB);
        @(negedge clk);
        base = dut_pulses;
        pressed[2*4+2] = 1'b1;
        repeat (8) @(negedge clk);
        release_all();
        repeat (4) @(posedge clk); #1;
        check("bounce9 resumes col3", 32'(COL), 32'h7);
        repeat (20) @(posedge clk); #2;
        check("bounce9 pulses", 32'(dut_pulses - base), 32'd0);
        check("bounce9 KEY kept", 32'(KEY), 32'h5);

        // Two keys in column 3, lowest row wins.
        @(negedge clk);
        base = dut_pulses;
        pressed[0*4+3] = 1'b1;
        pressed[2*4+3] = 1'b1;
        wait_pulse("dual", 100);
        repeat (20) @(posedge clk); #2;
        check("dual pulses", 32'(dut_pulses - base), 32'd1);
        check("dual KEY", 32'(KEY), 32'hA);
        @(negedge clk);
        release_all();
        wait_held_low("dual", 16);

        // Long hold of '#'.
        @(negedge clk);
        base = dut_pulses;
        pressed[3*4+2] = 1'b1;
        repeat (200) @(posedge clk); #2;
        check("hash pulses", 32'(dut_pulses - base), 32'd1);
        check("hash KEY", 32'(KEY), 32'hF);
        @(negedge clk);
        release_all();
        wait_held_low("hash", 16);

        // Then 'A'.
        @(negedge clk);
        base = dut_pulses;
        pressed[0*4+3] = 1'b1;
        wait_pulse("keyA", 100);
        check("keyA KEY", 32'(KEY), 32'hA);
        @(negedge clk);
        release_all();
        wait_held_low("keyA", 16);
        check("keyA pulses", 32'(dut_pulses - base), 32'd1);

        // Reset while debouncing '1', then re-debounce after reset.
        wait_col_enter("rst1", 4'hE);
        @(negedge clk);
        base = dut_pulses;
        pressed[0] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst COL", 32'(COL), 32'hE);
        check("midrst KEY", 32'(KEY), 32'h0);
        check("midrst valid", 32'(key_valid), 32'h0);
        check("midrst held", 32'(key_held), 32'h0);
        repeat (3) @(negedge clk);
        check("midrst no pulse", 32'(dut_pulses - base), 32'd0);
        rst = 1'b0;
        wait_pulse("key1", 60);
        check("key1 KEY", 32'(KEY), 32'h1);
        repeat (20) @(posedge clk); #2;
        check("key1 pulses", 32'(dut_pulses - base), 32'd1);
        @(negedge clk);
        release_all();
        wait_held_low("key1", 16);

        repeat (4) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
